// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Adds two WIDTH-bit operands one bit per clock through an external,
//   purely combinational 1-bit full-adder slice, LSB first. This block owns
//   the operand shift registers, carry flop, bit counter and handshakes.
//
//   State table:
//     S_IDLE | waiting for an operand set; in_ready high
//     S_RUN  | one bit per clock through the adder slice; fa_* active
//     S_DONE | result presented on sum/cout with out_valid until out_ready
//
// Ports:
//   ck, rst               clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (op_a, op_b, cin sampled on accept)
//   fa_a, fa_b, fa_ci     bits driven to the adder slice (0 outside RUN)
//   fa_s, fa_co           sum / carry returned by the slice, same cycle
//   out_valid / out_ready result handshake
//   sum, cout             registered result and final carry
//   busy                  high while in RUN or DONE
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_s,
    input  logic             fa_co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] s_sr_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             run;
    logic [WIDTH-1:0] s_sr_d;

    // The slice is combinational, so its inputs must be driven straight from
    // the current shift-register LSBs rather than through another flop.
    assign run   = (state_q == S_RUN);
    assign fa_a  = run & a_sr_q[0];
    assign fa_b  = run & b_sr_q[0];
    assign fa_ci = run & carry_q;

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at
    // the LSB.
    assign s_sr_d = {fa_s, s_sr_q[WIDTH-1:1]};

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            s_sr_q      <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sr_q     <= op_a;
                        b_sr_q     <= op_b;
                        carry_q    <= cin;
                        cnt_q      <= '0;
                        state_q    <= S_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end

                S_RUN: begin
                    s_sr_q  <= s_sr_d;
                    carry_q <= fa_co;
                    a_sr_q  <= a_sr_q >> 1;
                    b_sr_q  <= b_sr_q >> 1;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        // Explicit clear keeps non-power-of-two widths from
                        // leaving the counter at WIDTH.
                        cnt_q       <= '0;
                        sum_q       <= s_sr_d;
                        cout_q      <= fa_co;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign busy      = busy_q;

endmodule
